// File: rtl/uart_fifo_n.sv
// uart_fifo_n: single-clock UART with a 16x-oversampled receiver, configurable
// frame format and first-word-fall-through TX/RX FIFOs carrying per-word error flags.

module uart_fifo_n_fifo #(
  parameter int W       = 8,
  parameter int ADDRESS = 3
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         wr_i,
  input  logic [W-1:0] wdata_i,
  input  logic         rd_i,
  output logic [W-1:0] rdata_o,
  output logic         full_o,
  output logic         empty_o
);
  logic [W-1:0]     mem_q [2**ADDRESS];
  logic [ADDRESS:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic             wr_en, rd_en;

  assign full_o  = (wptr_q[ADDRESS] != rptr_q[ADDRESS]) &&
                   (wptr_q[ADDRESS-1:0] == rptr_q[ADDRESS-1:0]);
  assign empty_o = (wptr_q == rptr_q);
  assign wr_en   = wr_i && !full_o;
  assign rd_en   = rd_i && !empty_o;
  assign wptr_d  = wptr_q + (ADDRESS+1)'(wr_en);
  assign rptr_d  = rptr_q + (ADDRESS+1)'(rd_en);
  // Head is forced to zero while empty so the outputs read 0 out of reset.
  assign rdata_o = empty_o ? '0 : mem_q[rptr_q[ADDRESS-1:0]];

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (wr_en) mem_q[wptr_q[ADDRESS-1:0]] <= wdata_i;
  end
endmodule

// state    | meaning
// S_IDLE   | line idle (TX: waiting for FIFO data, RX: waiting for 1->0)
// S_START  | start bit
// S_DATA   | N data bits, LSB first
// S_PAR    | parity bit (never entered when PARITY=0)
// S_STOP   | stop bit(s); RX checks and pushes at the first one
module uart_fifo_n #(
  parameter int N       = 8,
  parameter int CLK_DIV = 27,
  parameter int PARITY  = 0,
  parameter int STOP    = 1,
  parameter int ADDRESS = 3
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         rx_i,
  output logic         tx_o,
  input  logic         loopback_i,
  input  logic [N-1:0] tx_data_i,
  input  logic         tx_wr_i,
  output logic         tx_full_o,
  output logic         tx_busy_o,
  output logic [N-1:0] rx_data_o,
  output logic         rx_perr_o,
  output logic         rx_ferr_o,
  input  logic         rx_rd_i,
  output logic         rx_empty_o,
  output logic         rx_ovr_o,
  input  logic         clr_ovr_i
);
  localparam int DW = $clog2(CLK_DIV);

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PAR, S_STOP} state_e;

  state_e         tx_state_q, tx_state_d, rx_state_q, rx_state_d;
  logic [DW-1:0]  tx_div_q, tx_div_d, rx_div_q, rx_div_d;
  logic [3:0]     tx_sub_q, tx_sub_d, rx_sub_q, rx_sub_d;
  logic [2:0]     tx_bit_q, tx_bit_d, rx_bit_q, rx_bit_d;
  logic [N-1:0]   tx_shift_q, tx_shift_d, rx_shift_q, rx_shift_d;
  logic           tx_par_q, tx_par_d, tx_o_q, tx_o_d, busy_q, busy_d;
  logic           rx_perr_q, rx_perr_d, ovr_q, ovr_d;
  logic           rx_s1_q, rx_s2_q, rx_prev_q;
  logic           tx_tick, tx_bit_end, tx_pop, tx_load, tx_empty;
  logic           rx_tick, rx_sample, rx_push, rx_full;
  logic [N-1:0]   tx_head;
  logic [N+1:0]   rx_wdata, rx_rdata;

  uart_fifo_n_fifo #(.W(N), .ADDRESS(ADDRESS)) u_tx_fifo (
    .clk_i(clk_i), .rst_i(rst_i), .wr_i(tx_wr_i), .wdata_i(tx_data_i),
    .rd_i(tx_pop), .rdata_o(tx_head), .full_o(tx_full_o), .empty_o(tx_empty)
  );

  uart_fifo_n_fifo #(.W(N+2), .ADDRESS(ADDRESS)) u_rx_fifo (
    .clk_i(clk_i), .rst_i(rst_i), .wr_i(rx_push), .wdata_i(rx_wdata),
    .rd_i(rx_rd_i), .rdata_o(rx_rdata), .full_o(rx_full), .empty_o(rx_empty_o)
  );

  assign tx_tick    = (tx_div_q == DW'(CLK_DIV-1));
  assign tx_bit_end = tx_tick && (tx_sub_q == 4'd15);

  always_comb begin
    tx_state_d = tx_state_q;
    tx_div_d   = tx_tick ? '0 : tx_div_q + 1'b1;
    tx_sub_d   = tx_tick ? tx_sub_q + 1'b1 : tx_sub_q;
    tx_bit_d   = tx_bit_q;
    tx_shift_d = tx_shift_q;
    tx_par_d   = tx_par_q;
    tx_load    = 1'b0;
    case (tx_state_q)
      S_IDLE:  tx_load = !tx_empty;
      S_START: if (tx_bit_end) begin
        tx_state_d = S_DATA;
        tx_bit_d   = '0;
      end
      S_DATA:  if (tx_bit_end) begin
        tx_shift_d = tx_shift_q >> 1;
        if (tx_bit_q == 3'(N-1)) begin
          tx_state_d = (PARITY != 0) ? S_PAR : S_STOP;
          tx_bit_d   = '0;
        end else begin
          tx_bit_d = tx_bit_q + 1'b1;
        end
      end
      S_PAR:   if (tx_bit_end) tx_state_d = S_STOP;
      S_STOP:  if (tx_bit_end) begin
        if (tx_bit_q == 3'(STOP-1)) begin
          tx_load    = !tx_empty;
          tx_state_d = S_IDLE;
        end else begin
          tx_bit_d = tx_bit_q + 1'b1;
        end
      end
      default: tx_state_d = S_IDLE;
    endcase
    // Loading restarts the bit timer so every frame starts on a full bit.
    if (tx_load) begin
      tx_state_d = S_START;
      tx_div_d   = '0;
      tx_sub_d   = '0;
      tx_shift_d = tx_head;
      tx_par_d   = (^tx_head) ^ (PARITY == 1);
    end
  end

  assign tx_pop = tx_load;
  assign busy_d = (tx_state_q != S_IDLE) || (tx_state_d != S_IDLE);

  always_comb begin
    tx_o_d = 1'b1;
    case (tx_state_q)
      S_START: tx_o_d = 1'b0;
      S_DATA:  tx_o_d = tx_shift_q[0];
      S_PAR:   tx_o_d = tx_par_q;
      default: tx_o_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      tx_state_q <= S_IDLE;
      tx_div_q   <= '0;
      tx_sub_q   <= '0;
      tx_bit_q   <= '0;
      tx_shift_q <= '0;
      tx_par_q   <= 1'b0;
      tx_o_q     <= 1'b1;
      busy_q     <= 1'b0;
    end else begin
      tx_state_q <= tx_state_d;
      tx_div_q   <= tx_div_d;
      tx_sub_q   <= tx_sub_d;
      tx_bit_q   <= tx_bit_d;
      tx_shift_q <= tx_shift_d;
      tx_par_q   <= tx_par_d;
      tx_o_q     <= tx_o_d;
      busy_q     <= busy_d;
    end
  end

  assign tx_o      = tx_o_q;
  assign tx_busy_o = busy_q || !tx_empty;

  // Receiver runs off its own free-running divider; sampling lands on the
  // 8th tick after the detected edge, within one tick of true mid-bit.
  assign rx_tick   = (rx_div_q == DW'(CLK_DIV-1));
  assign rx_div_d  = rx_tick ? '0 : rx_div_q + 1'b1;
  assign rx_sample = rx_tick && (rx_sub_q == 4'd7);
  assign rx_wdata  = {~rx_s2_q, rx_perr_q, rx_shift_q};

  always_comb begin
    rx_state_d = rx_state_q;
    rx_sub_d   = rx_tick ? rx_sub_q + 1'b1 : rx_sub_q;
    rx_bit_d   = rx_bit_q;
    rx_shift_d = rx_shift_q;
    rx_perr_d  = rx_perr_q;
    rx_push    = 1'b0;
    case (rx_state_q)
      S_IDLE:  if (rx_prev_q && !rx_s2_q) begin
        rx_state_d = S_START;
        rx_sub_d   = '0;
      end
      S_START: if (rx_sample) begin
        rx_state_d = rx_s2_q ? S_IDLE : S_DATA;
        rx_bit_d   = '0;
        rx_perr_d  = 1'b0;
      end
      S_DATA:  if (rx_sample) begin
        rx_shift_d = {rx_s2_q, rx_shift_q[N-1:1]};
        rx_bit_d   = rx_bit_q + 1'b1;
        if (rx_bit_q == 3'(N-1)) rx_state_d = (PARITY != 0) ? S_PAR : S_STOP;
      end
      S_PAR:   if (rx_sample) begin
        rx_perr_d  = rx_s2_q ^ (^rx_shift_q) ^ (PARITY == 1);
        rx_state_d = S_STOP;
      end
      S_STOP:  if (rx_sample) begin
        rx_push    = 1'b1;
        rx_state_d = S_IDLE;
      end
      default: rx_state_d = S_IDLE;
    endcase
  end

  assign ovr_d = (rx_push && rx_full) ? 1'b1 : (clr_ovr_i ? 1'b0 : ovr_q);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rx_state_q <= S_IDLE;
      rx_div_q   <= '0;
      rx_sub_q   <= '0;
      rx_bit_q   <= '0;
      rx_shift_q <= '0;
      rx_perr_q  <= 1'b0;
      ovr_q      <= 1'b0;
      rx_s1_q    <= 1'b1;
      rx_s2_q    <= 1'b1;
      rx_prev_q  <= 1'b1;
    end else begin
      rx_state_q <= rx_state_d;
      rx_div_q   <= rx_div_d;
      rx_sub_q   <= rx_sub_d;
      rx_bit_q   <= rx_bit_d;
      rx_shift_q <= rx_shift_d;
      rx_perr_q  <= rx_perr_d;
      ovr_q      <= ovr_d;
      rx_s1_q    <= loopback_i ? tx_o_q : rx_i;
      rx_s2_q    <= rx_s1_q;
      rx_prev_q  <= rx_s2_q;
    end
  end

  assign {rx_ferr_o, rx_perr_o, rx_data_o} = rx_rdata;
  assign rx_ovr_o = ovr_q;
endmodule
